div_ctrl: RTL and testbench
===========================

# div_ctrl

Iterative RV32M divide sequencer beside the `ex` stage. When `ex` decodes DIV, DIVU, REM or REMU, it hands the operands and destination to this block. The block holds the pipeline, runs a 32-step shift-subtract loop on one shared datapath, and returns the result with its register write-back controls for one cycle. It also owns divide-by-zero, signed-overflow and abort (flush) handling.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start_i`  in  1  single-cycle divide request from `ex`
- `op_i`  in  3  func3 of the instruction: 3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU
- `dividend_i`  in  32  rs1 value (op1)
- `divisor_i`  in  32  rs2 value (op2)
- `rd_addr_i`  in  5  destination register
- `reg_wen_i`  in  1  write enable carried from decode
- `abort_i`  in  1  pipeline flush (jump taken); cancels the divide in flight
- `busy_o`  out  1  state is not IDLE
- `hold_o`  out  1  stall request to pipeline control
- `ready_o`  out  1  result valid this cycle
- `result_o`  out  32  quotient or remainder
- `rd_addr_o`  out  5  destination register, valid with `ready_o`
- `rd_wen_o`  out  1  write enable, valid with `ready_o`

## Operation
- States: IDLE, CALC, END.
- IDLE, with `start_i`=1 and `abort_i`=0:
  - register `op_i`, `rd_addr_i` and `reg_wen_i`;
  - register the magnitude of each operand (two's-complement absolute value for DIV/REM, raw value for DIVU/REMU);
  - register the result sign: quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend);
  - clear the remainder register, load the quotient shift register with the dividend magnitude, set count = 31;
  - go to CALC.
- CALC, one bit per cycle:
  - partial = {rem[30:0], q[31]};
  - if partial ≥ divisor magnitude: rem = partial − divisor, shift a 1 into q;
  - else: rem = partial, shift a 0 into q;
  - decrement count; after the count==0 step, go to END.
  - All arithmetic is 32-bit unsigned; the compare uses a 33-bit subtract so no carry is lost.
- END:
  - `ready_o`=1 for exactly one cycle;
  - `result_o` is the quotient (DIV/DIVU) or remainder (REM/REMU), negated when its registered sign is set and the op is signed;
  - return to IDLE.
- Divisor == 0: quotient = 0xFFFFFFFF; remainder = original dividend. Neither is sign-corrected.
- Overflow (DIV or REM of 0x80000000 by 0xFFFFFFFF): quotient = 0x80000000, remainder = 0. The magnitude path yields this naturally; no special case is needed.
- `start_i` outside IDLE is ignored. `ex` is stalled then, so it never issues one.
- `abort_i` in any state: IDLE at the next edge, no `ready_o`. If `abort_i` and `start_i` are both high in IDLE, abort wins and nothing is captured.

## Timing
- Reset (asynchronous) forces IDLE, clears all registers, and drives every output to 0.
- Outside END, `result_o`, `rd_addr_o` and `rd_wen_o` are 0.
- `hold_o` = (IDLE & `start_i` & !`abort_i`) | CALC. It is combinational, so the stall takes effect in the request cycle. It is low in END, so the pipeline advances as the result is written.
- Latency: `start_i` in cycle 0; CALC spans cycles 1–32; `ready_o` in cycle 33.
- Back-to-back: the next `start_i` is accepted in the cycle after END, at the earliest.
- Reset deasserted mid-operation: the block sits in IDLE; no stale `ready_o`.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - in IDLE, a zero divisor, or a dividend magnitude smaller than the divisor magnitude, loads the final quotient/remainder directly and skips CALC;
  - the state goes straight to END, so `ready_o` asserts in cycle 1;
  - `hold_o` is then high only in cycle 0.
- `DIV_EARLY_OUT_EN` undefined: every divide takes the full 33-cycle path with identical results.

## Structure
- Shared defines header holds:
  - the func3 codes (`INST_DIV`, `INST_DIVU`, `INST_REM`, `INST_REMU`);
  - the opcode `INST_TYPE_R_M`;
  - the `div_ctrl` state encodings (2-bit).
- Single module, no sub-module. The iteration step and sign fix are small enough to stay inline.
- Pipeline control ORs `hold_o` into its stall and treats `abort_i` as the existing jump flush.

## Test plan
- DIVU 100/7, start at cycle 0 -> `ready_o` at cycle 33, `result_o`=14, rd_addr/wen echoed; REMU 100/7 -> 2.
- DIV −7/2 (0xFFFFFFF9, 0x2) -> 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF; DIV 7/−2 -> 0xFFFFFFFD.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; with `DIV_EARLY_OUT_EN`, `ready_o` at cycle 1.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- `abort_i` at cycle 10 -> no `ready_o`, `busy_o`=0 at cycle 11, new `start_i` at cycle 11 accepted and completes at cycle 44.
- `rst` pulse at cycle 5 mid-divide -> all outputs 0 immediately, IDLE after release, no `ready_o`.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// div_ctrl shared definitions: RV32M func3 codes, opcode, state encodings.
// Optional early-out path is enabled by defining DIV_EARLY_OUT_EN.
package div_ctrl_pkg;

  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_END  = 2'd2
  } state_t;

  // Select quotient or remainder and apply its sign correction.
  function automatic logic [31:0] fix_result(
    input logic        is_rem,
    input logic [31:0] q,
    input logic [31:0] r,
    input logic        q_neg,
    input logic        r_neg
  );
    logic [31:0] v;
    logic        n;
    v = is_rem ? r : q;
    n = is_rem ? r_neg : q_neg;
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// div_ctrl request/response bundle between ex and the divider.
// master = ex side, slave = divider side.
interface div_ctrl_if;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic        reg_wen_i;
  logic        abort_i;
  logic        busy_o;
  logic        hold_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;
  logic        rd_wen_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i,
    output rd_addr_i, reg_wen_i, abort_i,
    input  busy_o, hold_o, ready_o,
    input  result_o, rd_addr_o, rd_wen_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i,
    input  rd_addr_i, reg_wen_i, abort_i,
    output busy_o, hold_o, ready_o,
    output result_o, rd_addr_o, rd_wen_o
  );
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: iterative 32-step shift-subtract RV32M divider beside ex.
// Define DIV_EARLY_OUT_EN to skip CALC for zero or oversized divisors.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input logic       clk,
  input logic       rst,
  div_ctrl_if.slave bus
);

  state_t      state;
  logic [31:0] q;
  logic [31:0] rem;
  logic [31:0] dsr;
  logic [4:0]  cnt;
  logic        is_rem;
  logic        q_neg;
  logic        r_neg;
  logic [4:0]  rd_q;
  logic        wen_q;
  logic        ready;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        wen_out;

  logic        sgn_in;
  logic        rem_in;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        b_zero;
  logic        q_neg_in;
  logic        r_neg_in;
  logic        accept;
  logic        early;
  logic [31:0] early_q;
  logic [31:0] partial;
  logic [32:0] diff;
  logic        ge;
  logic [31:0] rem_n;
  logic [31:0] q_n;

  // Decode the request operands into magnitudes and result signs.
  always_comb begin
    sgn_in = 1'b0;
    rem_in = 1'b0;
    unique case (bus.op_i)
      INST_DIV:  sgn_in = 1'b1;
      INST_DIVU: sgn_in = 1'b0;
      INST_REM: begin
        sgn_in = 1'b1;
        rem_in = 1'b1;
      end
      INST_REMU: rem_in = 1'b1;
      default:   sgn_in = 1'b0;
    endcase
    a_neg    = sgn_in & bus.dividend_i[31];
    b_neg    = sgn_in & bus.divisor_i[31];
    a_mag    = a_neg ? (~bus.dividend_i + 32'd1) : bus.dividend_i;
    b_mag    = b_neg ? (~bus.divisor_i + 32'd1) : bus.divisor_i;
    b_zero   = (bus.divisor_i == 32'd0);
    q_neg_in = (a_neg ^ b_neg) & ~b_zero;
    r_neg_in = a_neg;
    early_q  = b_zero ? 32'hFFFF_FFFF : 32'd0;
  end

  assign accept = (state == S_IDLE) & bus.start_i & ~bus.abort_i;

`ifdef DIV_EARLY_OUT_EN
  assign early = b_zero | (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  // One restoring-division step on the shared datapath.
  always_comb begin
    partial = {rem[30:0], q[31]};
    diff    = {1'b0, partial} - {1'b0, dsr};
    ge      = ~diff[32];
    rem_n   = ge ? diff[31:0] : partial;
    q_n     = {q[30:0], ge};
  end

  // Sequencer: capture, iterate, present the result for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      q       <= '0;
      rem     <= '0;
      dsr     <= '0;
      cnt     <= '0;
      is_rem  <= 1'b0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      ready   <= 1'b0;
      result  <= '0;
      rd_out  <= '0;
      wen_out <= 1'b0;
    end else begin
      ready   <= 1'b0;
      result  <= '0;
      rd_out  <= '0;
      wen_out <= 1'b0;
      if (bus.abort_i) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (accept) begin
              is_rem <= rem_in;
              q_neg  <= q_neg_in;
              r_neg  <= r_neg_in;
              rd_q   <= bus.rd_addr_i;
              wen_q  <= bus.reg_wen_i;
              rem    <= '0;
              q      <= a_mag;
              dsr    <= b_mag;
              cnt    <= 5'd31;
              if (early) begin
                state   <= S_END;
                ready   <= 1'b1;
                result  <= fix_result(rem_in, early_q, a_mag,
                                      q_neg_in, r_neg_in);
                rd_out  <= bus.rd_addr_i;
                wen_out <= bus.reg_wen_i;
              end else begin
                state <= S_CALC;
              end
            end
          end
          S_CALC: begin
            q   <= q_n;
            rem <= rem_n;
            cnt <= cnt - 5'd1;
            if (cnt == 5'd0) begin
              state   <= S_END;
              ready   <= 1'b1;
              result  <= fix_result(is_rem, q_n, rem_n, q_neg, r_neg);
              rd_out  <= rd_q;
              wen_out <= wen_q;
            end
          end
          S_END:   state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy_o    = (state != S_IDLE);
  assign bus.hold_o    = ~rst & (accept | (state == S_CALC));
  assign bus.ready_o   = ready;
  assign bus.result_o  = result;
  assign bus.rd_addr_o = rd_out;
  assign bus.rd_wen_o  = wen_out;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed vectors for div_ctrl with hand-computed results.
// Latency expectations follow DIV_EARLY_OUT_EN when it is defined.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  div_ctrl_if bus ();

  div_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef DIV_EARLY_OUT_EN
  localparam int ELAT = 1;
`else
  localparam int ELAT = 33;
`endif
  localparam int FLAT = 33;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    bus.start_i    = 1'b0;
    bus.abort_i    = 1'b0;
    bus.op_i       = 3'b000;
    bus.dividend_i = 32'd0;
    bus.divisor_i  = 32'd0;
    bus.rd_addr_i  = 5'd0;
    bus.reg_wen_i  = 1'b0;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic wen);
    bus.start_i    = 1'b1;
    bus.op_i       = op;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.rd_addr_i  = rd;
    bus.reg_wen_i  = wen;
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic wen,
                        input logic [31:0] exp, input int lat);
    int n;
    drive(op, a, b, rd, wen);
    #1 check({tag, ".hold0"}, 32'(bus.hold_o), 32'd1);
    @(negedge clk);
    idle_in();
    n = 1;
    #1 check({tag, ".hold1"}, 32'(bus.hold_o), (lat > 1) ? 32'd1 : 32'd0);
    while (!bus.ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".lat"}, n, lat);
    check({tag, ".res"}, bus.result_o, exp);
    check({tag, ".rd"}, 32'(bus.rd_addr_o), 32'(rd));
    check({tag, ".wen"}, 32'(bus.rd_wen_o), 32'(wen));
    check({tag, ".hold_end"}, 32'(bus.hold_o), 32'd0);
    @(negedge clk);
    check({tag, ".rdy_off"}, 32'(bus.ready_o), 32'd0);
    check({tag, ".res_off"}, bus.result_o, 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    idle_in();
    #1;
    check("rst.busy", 32'(bus.busy_o), 32'd0);
    check("rst.ready", 32'(bus.ready_o), 32'd0);
    check("rst.result", bus.result_o, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("divu_100_7", INST_DIVU, 32'd100, 32'd7, 5'd3, 1'b1,
           32'd14, FLAT);
    run_op("remu_100_7", INST_REMU, 32'd100, 32'd7, 5'd17, 1'b0,
           32'd2, FLAT);
    run_op("div_m7_2", INST_DIV, 32'hFFFF_FFF9, 32'd2, 5'd31, 1'b1,
           32'hFFFF_FFFD, FLAT);
    run_op("rem_m7_2", INST_REM, 32'hFFFF_FFF9, 32'd2, 5'd1, 1'b1,
           32'hFFFF_FFFF, FLAT);
    run_op("div_7_m2", INST_DIV, 32'd7, 32'hFFFF_FFFE, 5'd5, 1'b1,
           32'hFFFF_FFFD, FLAT);
    run_op("div_5_0", INST_DIV, 32'd5, 32'd0, 5'd6, 1'b1,
           32'hFFFF_FFFF, ELAT);
    run_op("remu_5_0", INST_REMU, 32'd5, 32'd0, 5'd7, 1'b1,
           32'd5, ELAT);
    run_op("div_m5_0", INST_DIV, 32'hFFFF_FFFB, 32'd0, 5'd8, 1'b1,
           32'hFFFF_FFFF, ELAT);
    run_op("rem_m5_0", INST_REM, 32'hFFFF_FFFB, 32'd0, 5'd9, 1'b1,
           32'hFFFF_FFFB, ELAT);
    run_op("div_ovf", INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10,
           1'b1, 32'h8000_0000, FLAT);
    run_op("rem_ovf", INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11,
           1'b1, 32'd0, FLAT);
    run_op("divu_big", INST_DIVU, 32'hFFFF_FFFF, 32'h10, 5'd12, 1'b1,
           32'h0FFF_FFFF, FLAT);
    run_op("remu_big", INST_REMU, 32'hFFFF_FFFF, 32'h10, 5'd13, 1'b1,
           32'hF, FLAT);
    run_op("divu_3_10", INST_DIVU, 32'd3, 32'd10, 5'd14, 1'b1,
           32'd0, ELAT);
    run_op("rem_m3_10", INST_REM, 32'hFFFF_FFFD, 32'd10, 5'd15, 1'b1,
           32'hFFFF_FFFD, ELAT);

    // abort and start in the same idle cycle: abort wins
    drive(INST_DIVU, 32'd100, 32'd7, 5'd2, 1'b1);
    bus.abort_i = 1'b1;
    #1 check("abst.hold", 32'(bus.hold_o), 32'd0);
    @(negedge clk);
    idle_in();
    #1 check("abst.busy", 32'(bus.busy_o), 32'd0);
    @(negedge clk);

    // abort in cycle 10, restart in cycle 11
    drive(INST_DIVU, 32'd100, 32'd7, 5'd4, 1'b1);
    seen = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      idle_in();
      if (bus.ready_o) seen++;
    end
    check("abort.busy10", 32'(bus.busy_o), 32'd1);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    if (bus.ready_o) seen++;
    check("abort.noready", seen, 32'd0);
    check("abort.busy11", 32'(bus.busy_o), 32'd0);
    run_op("after_abort", INST_DIVU, 32'd100, 32'd7, 5'd20, 1'b1,
           32'd14, FLAT);

    // asynchronous reset in cycle 5 of a divide
    drive(INST_DIVU, 32'd100, 32'd7, 5'd21, 1'b1);
    @(negedge clk);
    idle_in();
    repeat (4) @(negedge clk);
    check("mrst.busy_pre", 32'(bus.busy_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mrst.busy", 32'(bus.busy_o), 32'd0);
    check("mrst.hold", 32'(bus.hold_o), 32'd0);
    check("mrst.ready", 32'(bus.ready_o), 32'd0);
    check("mrst.result", bus.result_o, 32'd0);
    check("mrst.rd", 32'(bus.rd_addr_o), 32'd0);
    check("mrst.wen", 32'(bus.rd_wen_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ready_o || bus.busy_o) seen++;
    end
    check("mrst.quiet", seen, 32'd0);
    run_op("after_rst", INST_REMU, 32'd100, 32'd7, 5'd22, 1'b1,
           32'd2, FLAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
